// File: rtl/grau_pertinencia_trapezio_pkg.sv
// Shared definitions for the trapezoidal membership-degree block.
//   W_FRAC_DEF : default degree width / division steps per term
//   GRAU_MAX   : degree value representing 1.0 at the default width
//   estado_t   : controller states (IDLE, DIV1, DIV2, DONE)
//   pre_t      : outcome of the per-term pre-checks
//   pre_check  : resolves a term without division when possible
package grau_pertinencia_trapezio_pkg;

    localparam int unsigned W_FRAC_DEF = 8;
    localparam logic [W_FRAC_DEF-1:0] GRAU_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV1 = 2'd1,
        ST_DIV2 = 2'd2,
        ST_DONE = 2'd3
    } estado_t;

    typedef enum logic [1:0] {
        PRE_DIVIDE = 2'd0,
        PRE_ZERO   = 2'd1,
        PRE_ONE    = 2'd2
    } pre_t;

    // Order matters: a negative numerator wins over a zero denominator.
    function automatic pre_t pre_check(input logic signed [31:0] num,
                                       input logic signed [31:0] den);
        if (num < 0)
            return PRE_ZERO;
        else if (den == 0)
            return PRE_ONE;
        else if (den < 0)
            return PRE_ZERO;
        else if (num >= den)
            return PRE_ONE;
        else
            return PRE_DIVIDE;
    endfunction

endpackage

// File: rtl/grau_pertinencia_trapezio_divisor.sv
// divisor_fracionario: iterative restoring divider producing
// floor(num * 2^W_FRAC / den), one quotient bit per i_step cycle, MSB first,
// with pre-checks that force 0 or all-ones for out-of-range terms.
//   clk, rst_n : clock, synchronous active-low reset
//   i_step     : perform one division step this cycle
//   i_first    : this step is the first of a term (operands taken from i_num/i_den)
//   i_num      : numerator, two's complement
//   i_den      : denominator, two's complement
//   o_result   : term value after the current step (valid on the last step)
module divisor_fracionario
    import grau_pertinencia_trapezio_pkg::*;
#(
    parameter int unsigned W_FRAC = W_FRAC_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_step,
    input  logic              i_first,
    input  logic [31:0]       i_num,
    input  logic [31:0]       i_den,
    output logic [W_FRAC-1:0] o_result
);

    localparam logic [W_FRAC-1:0] L_ONE =
        (W_FRAC == W_FRAC_DEF) ? W_FRAC'(GRAU_MAX) : '1;

    // 33 bits: remainder < den < 2^31 so the doubled value never overflows.
    logic [32:0]       r_rem;
    logic [31:0]       r_den;
    logic [W_FRAC-1:0] r_quot;
    pre_t              r_mode;

    logic [32:0]       w_rem_cur;
    logic [31:0]       w_den_cur;
    logic [W_FRAC-1:0] w_quot_cur;
    pre_t              w_mode_cur;
    logic [32:0]       w_rem_sh;
    logic              w_ge;
    logic [32:0]       w_rem_nxt;
    logic [W_FRAC-1:0] w_quot_nxt;

    // The first step of a term works straight from the operands, so no
    // separate load cycle is needed and each term takes exactly W_FRAC steps.
    always_comb begin
        w_rem_cur  = i_first ? {1'b0, i_num} : r_rem;
        w_den_cur  = i_first ? i_den : r_den;
        w_quot_cur = i_first ? '0 : r_quot;
        w_mode_cur = i_first ? pre_check(i_num, i_den) : r_mode;
        w_rem_sh   = w_rem_cur << 1;
        w_ge       = (w_rem_sh >= {1'b0, w_den_cur});
        w_rem_nxt  = w_ge ? (w_rem_sh - {1'b0, w_den_cur}) : w_rem_sh;
        w_quot_nxt = (w_quot_cur << 1) | W_FRAC'(w_ge);
    end

    always_comb begin
        case (w_mode_cur)
            PRE_ZERO: o_result = '0;
            PRE_ONE:  o_result = L_ONE;
            default:  o_result = w_quot_nxt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rem  <= '0;
            r_den  <= '0;
            r_quot <= '0;
            r_mode <= PRE_DIVIDE;
        end else if (i_step) begin
            r_rem  <= w_rem_nxt;
            r_den  <= w_den_cur;
            r_quot <= w_quot_nxt;
            r_mode <= w_mode_cur;
        end
    end

endmodule

// File: rtl/grau_pertinencia_trapezio.sv
// grau_pertinencia_trapezio: membership degree of a trapezoidal fuzzy set,
// Grau = min(T1, T2) with Ti = clamp(floor(Ni * 2^W_FRAC / Di), 0, 2^W_FRAC-1).
// One shared divider computes T1 (DIV1) then T2 (DIV2); fixed latency.
//   clk, rst_n      : clock, synchronous active-low reset
//   in_valid/ready  : operand handshake (ready only in IDLE)
//   Numerador_1     : x - a        Denominador_1 : b - a
//   Numerador_2     : d - x        Denominador_2 : d - c
//   Grau            : membership degree, all-ones = 1.0
//   out_valid/ready : result handshake
module grau_pertinencia_trapezio
    import grau_pertinencia_trapezio_pkg::*;
#(
    parameter int unsigned W_FRAC = W_FRAC_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       Numerador_1,
    input  logic [31:0]       Denominador_1,
    input  logic [31:0]       Numerador_2,
    input  logic [31:0]       Denominador_2,
    output logic [W_FRAC-1:0] Grau,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int unsigned CW = (W_FRAC > 1) ? $clog2(W_FRAC) : 1;

    estado_t           r_state;
    estado_t           w_next;
    logic [31:0]       r_n1;
    logic [31:0]       r_d1;
    logic [31:0]       r_n2;
    logic [31:0]       r_d2;
    logic [CW-1:0]     r_cnt;
    logic [W_FRAC-1:0] r_t1;
    logic [W_FRAC-1:0] r_grau;

    logic              w_accept;
    logic              w_step;
    logic              w_first;
    logic              w_last;
    logic [31:0]       w_num;
    logic [31:0]       w_den;
    logic [W_FRAC-1:0] w_term;

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        in_ready = 1'b0;
        w_step   = 1'b0;
        w_last   = (r_cnt == CW'(W_FRAC - 1));
        w_first  = (r_cnt == '0);
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    w_next = ST_DIV1;
            end
            ST_DIV1: begin
                w_step = 1'b1;
                if (w_last)
                    w_next = ST_DIV2;
            end
            ST_DIV2: begin
                w_step = 1'b1;
                if (w_last)
                    w_next = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready)
                    w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
        w_accept = in_valid && in_ready;
        w_num    = (r_state == ST_DIV2) ? r_n2 : r_n1;
        w_den    = (r_state == ST_DIV2) ? r_d2 : r_d1;
    end

    divisor_fracionario #(
        .W_FRAC (W_FRAC)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_step   (w_step),
        .i_first  (w_first),
        .i_num    (w_num),
        .i_den    (w_den),
        .o_result (w_term)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_n1   <= '0;
            r_d1   <= '0;
            r_n2   <= '0;
            r_d2   <= '0;
            r_cnt  <= '0;
            r_t1   <= '0;
            r_grau <= '0;
        end else begin
            if (w_accept) begin
                r_n1  <= Numerador_1;
                r_d1  <= Denominador_1;
                r_n2  <= Numerador_2;
                r_d2  <= Denominador_2;
                r_cnt <= '0;
            end
            if (w_step)
                r_cnt <= w_last ? '0 : r_cnt + CW'(1);
            if ((r_state == ST_DIV1) && w_last)
                r_t1 <= w_term;
            if ((r_state == ST_DIV2) && w_last)
                r_grau <= (w_term < r_t1) ? w_term : r_t1;
        end
    end

    assign out_valid = (r_state == ST_DONE);
    assign Grau      = r_grau;

endmodule
